sdram_burst_responder: RTL
==========================

# sdram_burst_responder

Read-burst responder for the word-addressed SDRAM client port used by the video framebuffer fetch and other burst readers. It accepts one burst command at a time and fetches BURST_LEN 16-bit words through a pipelined single-word memory backend into a local burst buffer. It then streams the words back on consecutive cycles and waits for the client's burst acknowledge before accepting the next command. It sits between the client arbiter and the SDRAM controller core.

## Interface
Parameters:
- BURST_LEN, 64: words per burst; power of two, 2..256.
- MAX_OUTSTANDING, 4: maximum backend requests granted but not yet answered; 1..15.

Ports:
- clk_i  in  1  single system clock; all logic rising-edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  client holds high until cmd_ready_o is seen high.
- cmd_ready_o  out  1  high only when idle and able to accept a command.
- cmd_rd_i  in  1  reserved; sampled and ignored; every burst is a read.
- cmd_addr_x16_i  in  24  start address in 16-bit words.
- rdy_o  out  1  idle status; same value as cmd_ready_o.
- resp_valid_o  out  1  one data beat per high cycle; no backpressure.
- resp_rdata_o  out  16  beat data; valid only while resp_valid_o is high.
- ack_i  in  1  single-cycle pulse from the client after the last beat.
- mem_req_o  out  1  backend read request; held until mem_gnt_i.
- mem_addr_o  out  24  backend word address.
- mem_gnt_i  in  1  request accepted in this cycle.
- mem_rvalid_i  in  1  in-order read data return.
- mem_rdata_i  in  16  returned word.
- err_o  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- States: IDLE, FETCH, STREAM, WAIT_ACK.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i && cmd_ready_o: latch the address and go to FETCH.
  - Clear req_cnt, rx_cnt, and out_cnt.
  - cmd_ready_o drops in the next cycle.
- FETCH, requests:
  - mem_req_o=1 while req_cnt<BURST_LEN and out_cnt<MAX_OUTSTANDING.
  - mem_addr_o = (base + req_cnt) mod 2^24; wraps across the full 24 bits.
  - mem_req_o and mem_addr_o are stable until granted.
  - Each cycle with mem_req_o && mem_gnt_i: req_cnt+1, out_cnt+1.
- FETCH, returns:
  - Each mem_rvalid_i writes mem_rdata_i to buf[rx_cnt]; rx_cnt+1, out_cnt-1.
  - Grant and rvalid in the same cycle leave out_cnt unchanged.
  - When rx_cnt reaches BURST_LEN: go to STREAM; the stream index is cleared.
- STREAM:
  - resp_valid_o=1 every cycle, resp_rdata_o=buf[idx], idx+1.
  - After beat BURST_LEN-1: go to WAIT_ACK.
- WAIT_ACK: on ack_i go to IDLE.
- Errors (each sets err_o; the offending event is ignored and the state is unchanged):
  - ack_i outside WAIT_ACK.
  - mem_rvalid_i with out_cnt==0.
  - mem_rvalid_i outside FETCH.
- cmd_valid_i outside IDLE is not an error; the command waits, because cmd_ready_o=0.
- Counters are $clog2(BURST_LEN)+1 bits wide; out_cnt is 4 bits.

## Timing
- Reset values: cmd_ready_o=0, rdy_o=0, resp_valid_o=0, resp_rdata_o=0, mem_req_o=0, mem_addr_o=0, err_o=0; state IDLE.
  - cmd_ready_o and rdy_o rise on the first clock edge after rst_ni deasserts.
- Reset mid-burst: everything aborts immediately; buffer contents are don't-care. The backend must be reset together; stale rvalid after reset flags err_o.
- All outputs are registered.
- Command handshake at cycle N: cmd_ready_o=0 and mem_req_o=1 (addr=base) at N+1.
- Zero-wait backend (gnt same cycle, rvalid one cycle after gnt): requests are issued at N+1..N+BURST_LEN.
- Last rvalid at cycle M: beats at M+1..M+BURST_LEN, contiguous; WAIT_ACK from M+BURST_LEN+1.
- ack_i at cycle A in WAIT_ACK: cmd_ready_o=1 at A+1; the earliest next handshake is at A+1.
- The client pulses ack_i in the cycle after the last beat, giving a 2-cycle turnaround.

## Test plan
- Basic burst: reset, cmd addr=0x080000, zero-wait backend returning data=addr[15:0] -> 64 contiguous beats 0x0000..0x003F, mem_addr_o 0x080000..0x08003F, err_o=0.
- Wrap: addr=0xFFFFF0, BURST_LEN=64 -> mem_addr_o sequence 0xFFFFF0..0xFFFFFF, then 0x000000..0x00002F.
- Backpressure/latency: gnt every 3rd cycle, rvalid 5 cycles after gnt -> out_cnt never exceeds 4, beats still contiguous and in order, correct data.
- Handshake: cmd_valid_i held high through a whole burst; ack_i at A -> second command accepted exactly at A+1, not earlier.
- Protocol errors: ack_i pulse during STREAM -> err_o=1 next cycle, burst completes normally; spurious mem_rvalid_i in IDLE -> err_o=1.
- Reset mid-FETCH after 10 grants -> all outputs 0 asynchronously, cmd_ready_o=1 one edge after release, fresh burst correct.

Source files
------------

// File: rtl/sdram_burst_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdram_burst_responder
// Purpose  : Fetches one BURST_LEN-word read burst through a pipelined backend
//            into a local buffer, then streams it back to the client.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_burst_responder #(
   parameter int BURST_LEN       = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_rd_i,
   input  logic [23:0] cmd_addr_x16_i,
   output logic        rdy_o,
   output logic        resp_valid_o,
   output logic [15:0] resp_rdata_o,
   input  logic        ack_i,
   output logic        mem_req_o,
   output logic [23:0] mem_addr_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [15:0] mem_rdata_i,
   output logic        err_o
);

   localparam int AW = $clog2(BURST_LEN);
   localparam int CW = AW + 1;

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_FETCH    = 2'd1;
   localparam logic [1:0] c_STREAM   = 2'd2;
   localparam logic [1:0] c_WAIT_ACK = 2'd3;

   localparam logic [CW-1:0] c_BURST_CNT = CW'(BURST_LEN);
   localparam logic [CW-1:0] c_LAST_RX   = CW'(BURST_LEN - 1);
   localparam logic [3:0]    c_MAX_OUT   = 4'(MAX_OUTSTANDING);

   logic [1:0]    r_state, w_state_d;
   logic [23:0]   r_base, w_base_d;
   logic [CW-1:0] r_req_cnt, w_req_cnt_d;
   logic [CW-1:0] r_rx_cnt, w_rx_cnt_d;
   logic [CW-1:0] r_idx, w_idx_d;
   logic [3:0]    r_out_cnt, w_out_cnt_d;
   logic [AW-1:0] w_rd_ptr;
   logic [15:0]   r_buf [BURST_LEN];

   logic          r_cmd_ready, w_cmd_ready_d;
   logic          r_mem_req, w_mem_req_d;
   logic [23:0]   r_mem_addr, w_mem_addr_d;
   logic          r_resp_valid, w_resp_valid_d;
   logic [15:0]   r_resp_rdata, w_resp_rdata_d;
   logic          r_err, w_err_d;

   logic          w_cmd_fire, w_gnt_ok, w_rx_ok;
   logic          w_unused_cmd_rd;

   assign w_unused_cmd_rd = cmd_rd_i;
   assign w_cmd_fire      = cmd_valid_i & r_cmd_ready;
   assign w_gnt_ok        = r_mem_req & mem_gnt_i;
   // A return is only legal while fetching with a request actually in flight.
   assign w_rx_ok         = mem_rvalid_i & (r_state == c_FETCH) & (r_out_cnt != 4'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= c_IDLE;
      else         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         c_IDLE:     if (w_cmd_fire) w_state_d = c_FETCH;
         c_FETCH:    if (w_rx_ok && (r_rx_cnt == c_LAST_RX)) w_state_d = c_STREAM;
         c_STREAM:   if (r_idx == c_BURST_CNT) w_state_d = c_WAIT_ACK;
         c_WAIT_ACK: if (ack_i) w_state_d = c_IDLE;
         default:    w_state_d = c_IDLE;
      endcase
   end

   // Outputs are registered, so everything is computed from next-cycle values.
   always_comb begin
      w_base_d = r_base;
      if (r_state == c_IDLE) begin
         w_req_cnt_d = '0;
         w_rx_cnt_d  = '0;
         w_out_cnt_d = 4'd0;
         if (w_cmd_fire) w_base_d = cmd_addr_x16_i;
      end else begin
         w_req_cnt_d = r_req_cnt + CW'(w_gnt_ok);
         w_rx_cnt_d  = r_rx_cnt + CW'(w_rx_ok);
         w_out_cnt_d = r_out_cnt + 4'(w_gnt_ok) - 4'(w_rx_ok);
      end
      w_rd_ptr       = (r_state == c_STREAM) ? r_idx[AW-1:0] : '0;
      w_resp_valid_d = (w_state_d == c_STREAM);
      w_idx_d        = w_resp_valid_d ? ({1'b0, w_rd_ptr} + CW'(1)) : '0;
      w_resp_rdata_d = w_resp_valid_d ? r_buf[w_rd_ptr] : r_resp_rdata;
      w_cmd_ready_d  = (w_state_d == c_IDLE);
      w_mem_req_d    = (w_state_d == c_FETCH) && (w_req_cnt_d < c_BURST_CNT)
                       && (w_out_cnt_d < c_MAX_OUT);
      w_mem_addr_d   = w_base_d + 24'(w_req_cnt_d);
      w_err_d        = r_err | (ack_i & (r_state != c_WAIT_ACK)) | (mem_rvalid_i & ~w_rx_ok);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_base       <= 24'd0;
         r_req_cnt    <= '0;
         r_rx_cnt     <= '0;
         r_idx        <= '0;
         r_out_cnt    <= 4'd0;
         r_cmd_ready  <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= 24'd0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 16'd0;
         r_err        <= 1'b0;
      end else begin
         r_base       <= w_base_d;
         r_req_cnt    <= w_req_cnt_d;
         r_rx_cnt     <= w_rx_cnt_d;
         r_idx        <= w_idx_d;
         r_out_cnt    <= w_out_cnt_d;
         r_cmd_ready  <= w_cmd_ready_d;
         r_mem_req    <= w_mem_req_d;
         r_mem_addr   <= w_mem_addr_d;
         r_resp_valid <= w_resp_valid_d;
         r_resp_rdata <= w_resp_rdata_d;
         r_err        <= w_err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_rx_ok) r_buf[r_rx_cnt[AW-1:0]] <= mem_rdata_i;
   end

   assign cmd_ready_o  = r_cmd_ready;
   assign rdy_o        = r_cmd_ready;
   assign mem_req_o    = r_mem_req;
   assign mem_addr_o   = r_mem_addr;
   assign resp_valid_o = r_resp_valid;
   assign resp_rdata_o = r_resp_rdata;
   assign err_o        = r_err;

endmodule
`default_nettype wire
